// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from two half-adder cells and
// a carry flip-flop. Each RUN cycle retires one sum bit, LSB first, into a
// shift register, so a full addition takes WIDTH cycles plus one DONE cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter only needs to reach WIDTH-1; the value after the last bit
    // is irrelevant because it is reloaded on every accepted start.
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s0;
    logic             c0;
    logic             s1;
    logic             c1;
    logic             accept;
    logic             last_bit;

    // Half-adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        half_add = {x & y, x ^ y};
    endfunction

    // Full adder for the current bit: operand bits first, then the stored carry.
    always_comb begin
        {c0, s0} = half_add(a_sr[0], b_sr[0]);
        {c1, s1} = half_add(s0, carry);
    end

    assign accept   = (state == ST_IDLE) && start;
    assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);

    // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset returns to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and one-bit-per-cycle shift; sum and carry hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr <= {s1, sum_sr[WIDTH-1:1]};
            carry  <= c0 | c1;
            cnt    <= cnt + CNT_ONE;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 and a WIDTH=16 instance share clock and
// reset. A timing/arithmetic model predicts busy, done, sum and cout every cycle;
// directed cases pin literal results, then a random back-to-back sweep runs.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_v[2];
    logic [15:0] a_v[2];
    logic [15:0] b_v[2];
    logic        cin_v[2];

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    logic        busy_a[2];
    logic        done_a[2];
    logic        cout_a[2];
    logic [15:0] sum_a[2];

    assign busy_a[0] = busy8;
    assign busy_a[1] = busy16;
    assign done_a[0] = done8;
    assign done_a[1] = done16;
    assign cout_a[0] = cout8;
    assign cout_a[1] = cout16;
    assign sum_a[0]  = {8'h00, sum8};
    assign sum_a[1]  = sum16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    // Reference result: plain integer addition of the masked operands.
    function automatic logic [16:0] ref_add(input int i, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        longint m;
        longint r;
        m = (longint'(1) << wid(i)) - 1;
        r = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
        return r[16:0];
    endfunction

    // Model: edge index of the last accepted start and its arithmetic result.
    // A start is accepted at edge n when no op is active, i.e. n >= acc + W + 2.
    int          cyc       = 0;
    int          m_acc[2]  = '{-1, -1};
    int          m_nacc[2] = '{0, 0};
    logic [16:0] m_res[2]  = '{17'd0, 17'd0};
    int          n_done[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_acc[i] <= -1;
                m_res[i] <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (start_v[i] === 1'b1 && (m_acc[i] < 0 || cyc >= m_acc[i] + wid(i) + 2)) begin
                    m_acc[i]  <= cyc;
                    m_res[i]  <= ref_add(i, a_v[i], b_v[i], cin_v[i]);
                    m_nacc[i] <= m_nacc[i] + 1;
                end
            end
        end
    end

    // Per-cycle compare: busy over edges [acc, acc+W], done at acc+W,
    // sum/cout checked whenever the op is not mid-RUN.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          e;
            int          w;
            logic        e_run;
            logic        e_busy;
            logic        e_done;
            logic [15:0] mask;
            w      = wid(i);
            e      = cyc - 1;
            e_run  = (m_acc[i] >= 0) && (e >= m_acc[i]) && (e < m_acc[i] + w);
            e_busy = (m_acc[i] >= 0) && (e >= m_acc[i]) && (e <= m_acc[i] + w);
            e_done = (m_acc[i] >= 0) && (e == m_acc[i] + w);
            mask   = (w == 8) ? 16'h00FF : 16'hFFFF;
            if (done_a[i] === 1'b1) n_done[i]++;
            check($sformatf("w%0d busy@%0d", w, e), {31'd0, busy_a[i]}, {31'd0, e_busy});
            check($sformatf("w%0d done@%0d", w, e), {31'd0, done_a[i]}, {31'd0, e_done});
            if (!e_run) begin
                check($sformatf("w%0d sum@%0d", w, e), {16'd0, sum_a[i]}, {16'd0, m_res[i][15:0] & mask});
                check($sformatf("w%0d cout@%0d", w, e), {31'd0, cout_a[i]}, {31'd0, m_res[i][w]});
            end
        end
    end

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy_a[i] !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle w%0d: busy still 0x%0h, expected 0x0", wid(i), busy_a[i]);
        end
    endtask

    // One 8-bit addition with literal expectations; ends on the done cycle.
    task automatic add8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec);
        int n;
        wait_idle(0);
        start_v[0] = 1'b1;
        a_v[0]     = {8'h00, a};
        b_v[0]     = {8'h00, b};
        cin_v[0]   = c;
        @(negedge clk);
        start_v[0] = 1'b0;
        a_v[0]     = 16'($urandom);
        b_v[0]     = 16'($urandom);
        cin_v[0]   = 1'($urandom_range(0, 1));
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        // done is visible WIDTH edges after the accepting edge.
        check({name, " latency"}, n, 8);
        check({name, " sum"}, {24'd0, sum8}, {24'd0, es});
        check({name, " cout"}, {31'd0, cout8}, {31'd0, ec});
    endtask

    task automatic sweep(input int i, input int nvec);
        int base_acc;
        int base_done;
        int n;
        wait_idle(i);
        base_acc  = m_nacc[i];
        base_done = n_done[i];
        n = 0;
        while (m_nacc[i] - base_acc < nvec && n < nvec * (wid(i) + 2) * 2 + 100) begin
            start_v[i] = ($urandom_range(0, 15) != 0);
            a_v[i]     = 16'($urandom);
            b_v[i]     = 16'($urandom);
            cin_v[i]   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) a_v[i] = 16'hFFFF;
            if ($urandom_range(0, 15) == 0) b_v[i] = 16'h0000;
            @(negedge clk);
            n++;
        end
        start_v[i] = 1'b0;
        check($sformatf("w%0d sweep accepts", wid(i)), m_nacc[i] - base_acc, nvec);
        wait_idle(i);
        @(negedge clk);
        #1;
        check($sformatf("w%0d sweep done pulses", wid(i)), n_done[i] - base_done, nvec);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            cin_v[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset busy8", {31'd0, busy8}, 0);
        check("reset done8", {31'd0, done8}, 0);
        check("reset sum8", {24'd0, sum8}, 0);
        check("reset cout8", {31'd0, cout8}, 0);
        check("reset sum16", {16'd0, sum16}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        add8("t1 5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        add8("t2 FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8("t2 FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        add8("t3 FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        add8("t3 00+00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Start held high with new operands through RUN and DONE.
        wait_idle(0);
        start_v[0] = 1'b1;
        a_v[0]     = 16'h0011;
        b_v[0]     = 16'h0022;
        cin_v[0]   = 1'b0;
        @(negedge clk);
        base     = n_done[0];
        a_v[0]   = 16'h00AA;
        b_v[0]   = 16'h0055;
        cin_v[0] = 1'b1;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4 first latency", n, 8);
        check("t4 first sum", {24'd0, sum8}, 32'h33);
        check("t4 first cout", {31'd0, cout8}, 0);
        @(negedge clk);
        check("t4 start in DONE ignored", {31'd0, busy8}, 0);
        @(negedge clk);
        check("t4 start in IDLE accepted", {31'd0, busy8}, 1);
        start_v[0] = 1'b0;
        a_v[0]     = 16'($urandom);
        b_v[0]     = 16'($urandom);
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4 second latency", n, 8);
        check("t4 second sum", {24'd0, sum8}, 32'h00);
        check("t4 second cout", {31'd0, cout8}, 1);
        #1;
        check("t4 done pulses", n_done[0] - base, 2);

        // Asynchronous reset in the middle of RUN (after the 4th RUN edge).
        wait_idle(0);
        start_v[0] = 1'b1;
        a_v[0]     = 16'h0077;
        b_v[0]     = 16'h0019;
        cin_v[0]   = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async busy", {31'd0, busy8}, 0);
        check("t5 async done", {31'd0, done8}, 0);
        check("t5 async sum", {24'd0, sum8}, 0);
        check("t5 async cout", {31'd0, cout8}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        base = n_done[0];
        repeat (12) @(negedge clk);
        #1;
        check("t5 no done after abort", n_done[0] - base, 0);
        @(negedge clk);
        add8("t5 12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        fork
            sweep(0, 1000);
            sweep(1, 1000);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
